// File: rtl/evm_ballot_unit.sv
// evm_ballot_unit: synchronises and debounces voter/officer buttons and drives the evm ballot handshake.
// Build option: define VOTER_TIMEOUT_EN to add the voter_timeout alarm output and TIMEOUT_CYCLES parameter.
module evm_ballot_unit #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned WIDTH           = 7
`ifdef VOTER_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES  = 255
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             switch_on_evm,
  input  logic             btn_c1,
  input  logic             btn_c2,
  input  logic             btn_c3,
  input  logic             btn_issue,
  input  logic             btn_close,
  input  logic             voting_in_progress,
  output logic             candidate_ready,
  output logic             vote_candidate_1,
  output logic             vote_candidate_2,
  output logic             vote_candidate_3,
  output logic             voting_session_done,
  output logic             ballot_lamp,
  output logic             multi_press_err,
  output logic [WIDTH-1:0] ballots_cast
`ifdef VOTER_TIMEOUT_EN
  ,
  output logic             voter_timeout
`endif
);

  localparam int unsigned NBTN      = 5;
  localparam int unsigned BTN_ISSUE = 3;
  localparam int unsigned BTN_CLOSE = 4;
  localparam int unsigned DCW       = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READY,
    S_ISSUE,
    S_ARMED,
    S_CAST,
    S_RELEASE,
    S_CLOSED
  } state_e;

  logic [NBTN-1:0]           raw;
  logic [NBTN-1:0]           sync1_q;
  logic [NBTN-1:0]           sync2_q;
  logic [NBTN-1:0]           db_q;
  logic [NBTN-1:0]           db_prev_q;
  logic [NBTN-1:0][DCW-1:0]  dcnt_q;
  logic [NBTN-1:0]           press;
  logic [2:0]                voter_db;
  logic [2:0]                voter_press;
  logic                      multi_c;
  logic                      vip_gate;

  state_e state_q, state_d;
  logic   err_ret_q, err_ret_d;
  logic   vip_seen_q, vip_seen_d;

  assign raw         = {btn_close, btn_issue, btn_c3, btn_c2, btn_c1};
  assign press       = db_q & ~db_prev_q;
  assign voter_db    = db_q[2:0];
  assign voter_press = press[2:0];
  assign multi_c     = (voter_db[0] & voter_db[1]) | (voter_db[0] & voter_db[2]) |
                       (voter_db[1] & voter_db[2]);
  assign vip_gate    = vip_seen_q | voting_in_progress;

  // Two-flop synchroniser followed by a consecutive-disagreement debounce counter per button
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      dcnt_q    <= '0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      for (int i = 0; i < int'(NBTN); i++) begin
        if (sync2_q[i] == db_q[i]) begin
          dcnt_q[i] <= '0;
        end else if (dcnt_q[i] == DCW'(DEBOUNCE_CYCLES - 1)) begin
          db_q[i]   <= sync2_q[i];
          dcnt_q[i] <= '0;
        end else begin
          dcnt_q[i] <= dcnt_q[i] + DCW'(1);
        end
      end
    end
  end

  // Next-state logic; power-off overrides everything
  always_comb begin
    state_d    = state_q;
    err_ret_d  = err_ret_q;
    vip_seen_d = vip_seen_q;
    if (!switch_on_evm) begin
      state_d    = S_IDLE;
      err_ret_d  = 1'b0;
      vip_seen_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_READY;
        S_READY: begin
          vip_seen_d = 1'b0;
          err_ret_d  = 1'b0;
          if (press[BTN_ISSUE]) begin
            state_d = S_ISSUE;
          end else if (press[BTN_CLOSE]) begin
            state_d = S_CLOSED;
          end
        end
        S_ISSUE: state_d = S_ARMED;
        S_ARMED: begin
          if (voting_in_progress) begin
            vip_seen_d = 1'b1;
          end
          // A press only counts once the evm has signalled it is waiting for the vote
          if (vip_gate && (|voter_press)) begin
            if (multi_c) begin
              state_d   = S_RELEASE;
              err_ret_d = 1'b1;
            end else begin
              state_d   = S_CAST;
              err_ret_d = 1'b0;
            end
          end
        end
        S_CAST: state_d = S_RELEASE;
        S_RELEASE: begin
          if (voter_db == 3'b000) begin
            state_d = err_ret_q ? S_ARMED : S_READY;
          end
        end
        S_CLOSED: state_d = S_CLOSED;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // State register and outputs registered from the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q             <= S_IDLE;
      err_ret_q           <= 1'b0;
      vip_seen_q          <= 1'b0;
      candidate_ready     <= 1'b0;
      vote_candidate_1    <= 1'b0;
      vote_candidate_2    <= 1'b0;
      vote_candidate_3    <= 1'b0;
      voting_session_done <= 1'b0;
      ballot_lamp         <= 1'b0;
      multi_press_err     <= 1'b0;
      ballots_cast        <= '0;
    end else begin
      state_q             <= state_d;
      err_ret_q           <= err_ret_d;
      vip_seen_q          <= vip_seen_d;
      candidate_ready     <= (state_d == S_ISSUE);
      vote_candidate_1    <= (state_d == S_CAST) && voter_db[0];
      vote_candidate_2    <= (state_d == S_CAST) && voter_db[1];
      vote_candidate_3    <= (state_d == S_CAST) && voter_db[2];
      voting_session_done <= (state_d == S_CLOSED);
      ballot_lamp         <= (state_d == S_ARMED);
      multi_press_err     <= (state_q == S_ARMED) && (state_d == S_RELEASE);
      if (!switch_on_evm) begin
        ballots_cast <= '0;
      end else if ((state_d == S_CAST) && (ballots_cast != '1)) begin
        ballots_cast <= ballots_cast + WIDTH'(1);
      end
    end
  end

`ifdef VOTER_TIMEOUT_EN
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TCW-1:0] tmo_cnt_q;

  // Level alarm for a voter idling in ARMED; an officer issue press re-arms the timer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q     <= '0;
      voter_timeout <= 1'b0;
    end else if (state_d != S_ARMED) begin
      tmo_cnt_q     <= '0;
      voter_timeout <= 1'b0;
    end else if ((state_q != S_ARMED) || press[BTN_ISSUE]) begin
      tmo_cnt_q     <= '0;
      voter_timeout <= 1'b0;
    end else if (tmo_cnt_q != TCW'(TIMEOUT_CYCLES)) begin
      tmo_cnt_q <= tmo_cnt_q + TCW'(1);
      if ((tmo_cnt_q + TCW'(1)) == TCW'(TIMEOUT_CYCLES)) begin
        voter_timeout <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_evm_ballot_unit.sv
// tb_evm_ballot_unit: randomized self-checking bench for evm_ballot_unit.
// A transaction-level scoreboard predicts pulse counts and ballots_cast from the ballot rules.
`timescale 1ns/1ps
module tb_evm_ballot_unit;

  localparam int unsigned DEB    = 4;
  localparam int unsigned W      = 7;
  localparam int unsigned LAT    = DEB + 3;
  localparam int unsigned SETTLE = DEB + 6;
  localparam int          SATMAX = (1 << W) - 1;
`ifdef VOTER_TIMEOUT_EN
  localparam int unsigned TMO    = 8;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         switch_on_evm = 1'b0;
  logic         btn_c1 = 1'b0, btn_c2 = 1'b0, btn_c3 = 1'b0;
  logic         btn_issue = 1'b0, btn_close = 1'b0;
  logic         voting_in_progress = 1'b0;
  logic         candidate_ready;
  logic         vote_candidate_1, vote_candidate_2, vote_candidate_3;
  logic         voting_session_done;
  logic         ballot_lamp;
  logic         multi_press_err;
  logic [W-1:0] ballots_cast;
`ifdef VOTER_TIMEOUT_EN
  logic         voter_timeout;
`endif

  evm_ballot_unit #(
    .DEBOUNCE_CYCLES(DEB),
    .WIDTH(W)
`ifdef VOTER_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(TMO)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .switch_on_evm(switch_on_evm),
    .btn_c1(btn_c1),
    .btn_c2(btn_c2),
    .btn_c3(btn_c3),
    .btn_issue(btn_issue),
    .btn_close(btn_close),
    .voting_in_progress(voting_in_progress),
    .candidate_ready(candidate_ready),
    .vote_candidate_1(vote_candidate_1),
    .vote_candidate_2(vote_candidate_2),
    .vote_candidate_3(vote_candidate_3),
    .voting_session_done(voting_session_done),
    .ballot_lamp(ballot_lamp),
    .multi_press_err(multi_press_err),
    .ballots_cast(ballots_cast)
`ifdef VOTER_TIMEOUT_EN
    ,
    .voter_timeout(voter_timeout)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Observed pulse-cycle counts and the scoreboard's expected counts
  int n_ready = 0, n_err = 0;
  int n_v[3] = '{0, 0, 0};
  int exp_ready = 0, exp_err = 0, exp_ballots = 0;
  int exp_v[3] = '{0, 0, 0};

  always @(negedge clk) begin
    if (candidate_ready)  n_ready++;
    if (vote_candidate_1) n_v[0]++;
    if (vote_candidate_2) n_v[1]++;
    if (vote_candidate_3) n_v[2]++;
    if (multi_press_err)  n_err++;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] outs();
    return {candidate_ready, vote_candidate_1, vote_candidate_2, vote_candidate_3,
            voting_session_done, ballot_lamp, multi_press_err};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int c, input logic v);
    case (c)
      0:       btn_c1 = v;
      1:       btn_c2 = v;
      default: btn_c3 = v;
    endcase
  endtask

  task automatic model_vote(input int c);
    exp_v[c]++;
    if (exp_ballots < SATMAX) exp_ballots++;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    switch_on_evm = 1'b0;
    {btn_c1, btn_c2, btn_c3, btn_issue, btn_close} = '0;
    voting_in_progress = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(2);
    exp_ballots = 0;
  endtask

  task automatic power_on();
    switch_on_evm = 1'b1;
    tick(3);
  endtask

  // Officer issues a ballot; returns once the issue button has debounced back low
  task automatic issue_ballot();
    btn_issue = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (candidate_ready) break;
    end
    tick(1);
    btn_issue = 1'b0;
    tick(SETTLE);
  endtask

  // Voter presses one button with optional sub-threshold bounce, holds, then releases
  task automatic cast_vote(input int c, input int bounces);
    for (int b = 0; b < bounces; b++) begin
      set_btn(c, 1'b1);
      tick(int'($urandom_range(DEB - 1, 1)));
      set_btn(c, 1'b0);
      tick(int'($urandom_range(DEB - 1, 1)));
    end
    set_btn(c, 1'b1);
    tick(LAT + 3);
    set_btn(c, 1'b0);
    tick(SETTLE);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    checks++;
    if (outs() !== 7'b0) begin
      failures++;
      $display("FAIL reset_outs: got %b expected 0000000", outs());
    end
    checks++;
    if (ballots_cast !== '0) begin
      failures++;
      $display("FAIL reset_ballots: got %0d expected 0", ballots_cast);
    end
    do_reset();
    power_on();
    checks++;
    if (outs() !== 7'b0 || ballots_cast !== '0) begin
      failures++;
      $display("FAIL ready_idle_outs: got %b/%0d expected 0000000/0", outs(), ballots_cast);
    end
  endtask

  task automatic test_normal_vote();
    int  edges;
    bit  seen;
    issue_ballot();
    exp_ready++;
    checks++;
    if (n_ready !== exp_ready) begin
      failures++;
      $display("FAIL issue_pulse: got %0d ready cycles expected %0d", n_ready, exp_ready);
    end
    checks++;
    if (ballot_lamp !== 1'b1) begin
      failures++;
      $display("FAIL lamp_armed: got %b expected 1", ballot_lamp);
    end
    voting_in_progress = 1'b1;
    btn_c2 = 1'b1;
    edges = 0;
    seen = 0;
    while (!seen && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (vote_candidate_2) seen = 1;
    end
    model_vote(1);
    checks++;
    if (!seen || edges != int'(LAT)) begin
      failures++;
      $display("FAIL vote_latency: got %0d edges (seen=%0d) expected %0d", edges, seen, LAT);
    end
    checks++;
    if (candidate_ready !== 1'b0 || ballots_cast !== W'(exp_ballots)) begin
      failures++;
      $display("FAIL cast_cycle: got ready=%b ballots=%0d expected ready=0 ballots=%0d",
               candidate_ready, ballots_cast, exp_ballots);
    end
    tick(4);
    btn_c2 = 1'b0;
    tick(SETTLE);
    checks++;
    if (n_v[0] !== exp_v[0] || n_v[1] !== exp_v[1] || n_v[2] !== exp_v[2]) begin
      failures++;
      $display("FAIL normal_votes: got %0d/%0d/%0d expected %0d/%0d/%0d",
               n_v[0], n_v[1], n_v[2], exp_v[0], exp_v[1], exp_v[2]);
    end
    checks++;
    if (ballot_lamp !== 1'b0) begin
      failures++;
      $display("FAIL lamp_after_vote: got %b expected 0", ballot_lamp);
    end
  endtask

  task automatic test_handshake();
    voting_in_progress = 1'b0;
    issue_ballot();
    exp_ready++;
    cast_vote(0, 0);
    checks++;
    if (n_v[0] !== exp_v[0] || ballot_lamp !== 1'b1) begin
      failures++;
      $display("FAIL no_vip_ignored: got votes=%0d lamp=%b expected votes=%0d lamp=1",
               n_v[0], ballot_lamp, exp_v[0]);
    end
    voting_in_progress = 1'b1;
    tick(1);
    voting_in_progress = 1'b0;
    cast_vote(0, 0);
    model_vote(0);
    checks++;
    if (n_v[0] !== exp_v[0] || ballots_cast !== W'(exp_ballots)) begin
      failures++;
      $display("FAIL vip_seen_vote: got votes=%0d ballots=%0d expected %0d/%0d",
               n_v[0], ballots_cast, exp_v[0], exp_ballots);
    end
    voting_in_progress = 1'b1;
  endtask

  task automatic test_bounce();
    issue_ballot();
    exp_ready++;
    for (int i = 0; i < 10; i++) begin
      btn_c1 = 1'b1;
      tick(1);
      btn_c1 = 1'b0;
      tick(1);
    end
    btn_c1 = 1'b1;
    tick(LAT + 5);
    btn_c1 = 1'b0;
    tick(SETTLE);
    model_vote(0);
    checks++;
    if (n_v[0] !== exp_v[0] || n_v[1] !== exp_v[1] || n_v[2] !== exp_v[2]) begin
      failures++;
      $display("FAIL bounce_votes: got %0d/%0d/%0d expected %0d/%0d/%0d",
               n_v[0], n_v[1], n_v[2], exp_v[0], exp_v[1], exp_v[2]);
    end
  endtask

  task automatic test_multi_press();
    issue_ballot();
    exp_ready++;
    btn_c1 = 1'b1;
    btn_c3 = 1'b1;
    tick(LAT + 3);
    exp_err++;
    checks++;
    if (n_err !== exp_err || n_v[0] !== exp_v[0] || n_v[2] !== exp_v[2] ||
        ballots_cast !== W'(exp_ballots)) begin
      failures++;
      $display("FAIL multi_reject: got err=%0d v1=%0d v3=%0d ballots=%0d expected %0d/%0d/%0d/%0d",
               n_err, n_v[0], n_v[2], ballots_cast, exp_err, exp_v[0], exp_v[2], exp_ballots);
    end
    btn_c1 = 1'b0;
    btn_c3 = 1'b0;
    tick(SETTLE);
    checks++;
    if (ballot_lamp !== 1'b1 || n_ready !== exp_ready) begin
      failures++;
      $display("FAIL multi_rearm: got lamp=%b ready=%0d expected lamp=1 ready=%0d",
               ballot_lamp, n_ready, exp_ready);
    end
    cast_vote(2, 0);
    model_vote(2);
    checks++;
    if (n_v[2] !== exp_v[2] || ballots_cast !== W'(exp_ballots)) begin
      failures++;
      $display("FAIL multi_then_vote: got v3=%0d ballots=%0d expected %0d/%0d",
               n_v[2], ballots_cast, exp_v[2], exp_ballots);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      int c;
      issue_ballot();
      exp_ready++;
      c = int'($urandom_range(2, 0));
      if ($urandom_range(3, 0) == 0) begin
        int o;
        o = (c + 1 + int'($urandom_range(1, 0))) % 3;
        set_btn(c, 1'b1);
        set_btn(o, 1'b1);
        tick(LAT + 3);
        set_btn(c, 1'b0);
        set_btn(o, 1'b0);
        tick(SETTLE);
        exp_err++;
      end
      cast_vote(c, int'($urandom_range(4, 0)));
      model_vote(c);
      checks++;
      if (n_v[0] !== exp_v[0] || n_v[1] !== exp_v[1] || n_v[2] !== exp_v[2] ||
          n_err !== exp_err || n_ready !== exp_ready || ballots_cast !== W'(exp_ballots)) begin
        failures++;
        $display("FAIL random_%0d: got v=%0d/%0d/%0d err=%0d rdy=%0d bal=%0d expected %0d/%0d/%0d %0d %0d %0d",
                 it, n_v[0], n_v[1], n_v[2], n_err, n_ready, ballots_cast,
                 exp_v[0], exp_v[1], exp_v[2], exp_err, exp_ready, exp_ballots);
      end
    end
  endtask

  task automatic test_power_off_in_cast();
    bit seen;
    issue_ballot();
    exp_ready++;
    btn_c1 = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (vote_candidate_1) begin
        seen = 1;
        break;
      end
    end
    switch_on_evm = 1'b0;
    exp_v[0]++;
    exp_ballots = 0;
    @(posedge clk);
    #1;
    checks++;
    if (!seen || outs() !== 7'b0 || ballots_cast !== '0) begin
      failures++;
      $display("FAIL power_off_cast: got seen=%0d outs=%b ballots=%0d expected 1/0000000/0",
               seen, outs(), ballots_cast);
    end
    btn_c1 = 1'b0;
    tick(SETTLE);
    power_on();
    issue_ballot();
    exp_ready++;
    checks++;
    if (n_ready !== exp_ready || ballot_lamp !== 1'b1) begin
      failures++;
      $display("FAIL power_back_on: got ready=%0d lamp=%b expected %0d/1", n_ready, ballot_lamp, exp_ready);
    end
    cast_vote(1, 0);
    model_vote(1);
  endtask

  task automatic test_reset_mid_armed();
    issue_ballot();
    exp_ready++;
    checks++;
    if (ballot_lamp !== 1'b1 || ballots_cast !== W'(exp_ballots)) begin
      failures++;
      $display("FAIL pre_reset_armed: got lamp=%b ballots=%0d expected 1/%0d",
               ballot_lamp, ballots_cast, exp_ballots);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (outs() !== 7'b0 || ballots_cast !== '0) begin
      failures++;
      $display("FAIL async_reset: got outs=%b ballots=%0d expected 0000000/0", outs(), ballots_cast);
    end
    do_reset();
    power_on();
    voting_in_progress = 1'b1;
  endtask

  task automatic test_close_saturation();
    for (int i = 0; i < SATMAX + 1; i++) begin
      int c;
      issue_ballot();
      exp_ready++;
      c = int'($urandom_range(2, 0));
      cast_vote(c, int'($urandom_range(2, 0)));
      model_vote(c);
      if (i == SATMAX - 1) begin
        checks++;
        if (ballots_cast !== W'(SATMAX)) begin
          failures++;
          $display("FAIL reach_max: got %0d expected %0d", ballots_cast, SATMAX);
        end
      end
    end
    checks++;
    if (ballots_cast !== W'(exp_ballots) || n_v[0] + n_v[1] + n_v[2] !== exp_v[0] + exp_v[1] + exp_v[2]) begin
      failures++;
      $display("FAIL saturate: got ballots=%0d votes=%0d expected %0d/%0d",
               ballots_cast, n_v[0] + n_v[1] + n_v[2], exp_ballots, exp_v[0] + exp_v[1] + exp_v[2]);
    end
    btn_issue = 1'b1;
    btn_close = 1'b1;
    tick(LAT + 3);
    btn_issue = 1'b0;
    btn_close = 1'b0;
    tick(SETTLE);
    exp_ready++;
    checks++;
    if (n_ready !== exp_ready || voting_session_done !== 1'b0 || ballot_lamp !== 1'b1) begin
      failures++;
      $display("FAIL issue_beats_close: got ready=%0d done=%b lamp=%b expected %0d/0/1",
               n_ready, voting_session_done, ballot_lamp, exp_ready);
    end
    cast_vote(0, 0);
    model_vote(0);
    btn_close = 1'b1;
    tick(LAT + 3);
    btn_close = 1'b0;
    tick(SETTLE + 20);
    checks++;
    if (voting_session_done !== 1'b1) begin
      failures++;
      $display("FAIL close_done: got %b expected 1", voting_session_done);
    end
    issue_ballot();
    cast_vote(2, 0);
    checks++;
    if (voting_session_done !== 1'b1 || n_ready !== exp_ready || n_v[2] !== exp_v[2]) begin
      failures++;
      $display("FAIL closed_ignores: got done=%b ready=%0d v3=%0d expected 1/%0d/%0d",
               voting_session_done, n_ready, n_v[2], exp_ready, exp_v[2]);
    end
    switch_on_evm = 1'b0;
    tick(2);
    exp_ballots = 0;
    checks++;
    if (voting_session_done !== 1'b0 || ballots_cast !== '0) begin
      failures++;
      $display("FAIL close_power_off: got done=%b ballots=%0d expected 0/0", voting_session_done, ballots_cast);
    end
    power_on();
  endtask

`ifdef VOTER_TIMEOUT_EN
  task automatic test_timeout();
    issue_ballot();
    exp_ready++;
    tick(TMO + 4);
    checks++;
    if (voter_timeout !== 1'b1) begin
      failures++;
      $display("FAIL timeout_set: got %b expected 1", voter_timeout);
    end
    btn_issue = 1'b1;
    tick(LAT + 2);
    checks++;
    if (voter_timeout !== 1'b0 || n_ready !== exp_ready) begin
      failures++;
      $display("FAIL timeout_clear: got tmo=%b ready=%0d expected 0/%0d", voter_timeout, n_ready, exp_ready);
    end
    btn_issue = 1'b0;
    tick(SETTLE);
    cast_vote(1, 0);
    model_vote(1);
    checks++;
    if (n_v[1] !== exp_v[1] || voter_timeout !== 1'b0 || ballots_cast !== W'(exp_ballots)) begin
      failures++;
      $display("FAIL timeout_vote: got v2=%0d tmo=%b ballots=%0d expected %0d/0/%0d",
               n_v[1], voter_timeout, ballots_cast, exp_v[1], exp_ballots);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_normal_vote();
    test_handshake();
    test_bounce();
    test_multi_press();
    test_random();
    test_power_off_in_cast();
    test_reset_mid_armed();
`ifdef VOTER_TIMEOUT_EN
    test_timeout();
`endif
    test_close_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
